pipe_skid_reg: RTL and testbench
================================

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32, payload width in bits (1..1024).
REQ-002 SHALL have parameter SKID_EN, default 1; 1 = two-entry skid buffer, 0 = single-entry register with combinational in_ready.
REQ-003 SHALL have parameter CLR_ON_FLUSH, default 1; 1 = payload registers zeroed on flush, 0 = payload retained.
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port flush, input, 1, synchronous pipeline flush.
REQ-007 SHALL have port in_valid, input, 1, upstream payload valid.
REQ-008 SHALL have port in_ready, output, 1, stage can accept this cycle.
REQ-009 SHALL have port in_data, input, DATA_W, upstream payload.
REQ-010 SHALL have port out_valid, output, 1, stage holds valid payload.
REQ-011 SHALL have port out_ready, input, 1, downstream accepts this cycle.
REQ-012 SHALL have port out_data, output, DATA_W, payload presented downstream.
REQ-013 SHALL have port occupancy, output, 2, entries held (0..2).

Function
REQ-014 SHALL define transfer-in = in_valid & in_ready and transfer-out = out_valid & out_ready in the same cycle.
REQ-015 SHALL, with SKID_EN=1, implement states EMPTY (occ 0), MAIN (occ 1), BOTH (occ 2, main + skid entry).
REQ-016 SHALL transition EMPTY->MAIN on transfer-in; MAIN->EMPTY on transfer-out without transfer-in; MAIN->BOTH on transfer-in without transfer-out; MAIN->MAIN on both (main loads in_data); BOTH->MAIN on transfer-out (main loads skid).
REQ-017 SHALL, with SKID_EN=1, drive in_ready from a register: 1 in EMPTY and MAIN, 0 in BOTH; in_ready SHALL NOT depend combinationally on out_ready.
REQ-018 SHALL, with SKID_EN=0, drive in_ready = ~out_valid | out_ready, and occupancy never exceeds 1.
REQ-019 SHALL drive out_data from the main entry only and out_valid = (occupancy != 0); latency in->out is exactly 1 cycle when EMPTY.
REQ-020 SHALL keep out_data stable while out_valid=1 and out_ready=0.
REQ-021 SHALL preserve arrival order; no payload duplicated or dropped except by flush.
REQ-022 SHALL, on flush=1, go to EMPTY next cycle, discard all held entries and any same-cycle transfer-in, and assert in_ready=1 next cycle.
REQ-023 SHALL give flush priority over every simultaneous handshake event; a same-cycle transfer-out still counts as delivered downstream.
REQ-024 SHALL, with CLR_ON_FLUSH=1, zero main and skid payload on flush; with 0, leave payload unchanged (only valid state cleared).
REQ-025 SHALL ignore in_data when in_valid=0; the main payload register SHALL NOT load when no entry enters it.

Reset
REQ-026 SHALL, while rst=0, asynchronously force state EMPTY, out_valid=0, occupancy=0, out_data=0, skid payload=0.
REQ-027 SHALL drive in_ready=1 during and after reset (SKID_EN=1: register reset value 1).
REQ-028 SHALL discard any in-flight handshake on reset assertion mid-operation; first post-reset transfer-in at the first rising edge after rst returns to 1.

Structure
REQ-029 SHALL take the state enum (EMPTY/MAIN/BOTH) from the shared CPU package, not a local declaration.
REQ-030 SHALL be a single module, no sub-modules; SKID_EN selects logic via generate.
REQ-031 SHALL be instantiable per pipeline boundary with DATA_W set to the packed width of that stage's bundle.

Verification
REQ-032 SHALL cover streaming: DATA_W=32, out_ready=1, push 0x11,0x22,0x33 back-to-back -> out_data 0x11,0x22,0x33 on consecutive cycles, one cycle delayed, occupancy stays 1.
REQ-033 SHALL cover backpressure: SKID_EN=1, out_ready=0, push 0xA,0xB,0xC -> 0xA,0xB accepted, in_ready=0 after 2nd, 0xC held upstream; release -> 0xA,0xB,0xC in order.
REQ-034 SHALL cover flush collision: state BOTH, flush=1 with in_valid=1 in_data=0xDEAD -> next cycle occupancy=0, out_valid=0, out_data=0, in_ready=1, 0xDEAD never emitted.
REQ-035 SHALL cover CLR_ON_FLUSH=0: hold 0x5A, flush -> out_valid=0, out_data=0x5A.
REQ-036 SHALL cover SKID_EN=0: out_valid=1, out_ready=1, in_valid=1 same cycle -> in_ready=1, replacement payload out next cycle, occupancy=1.
REQ-037 SHALL cover async reset mid-stream: rst=0 between edges while BOTH -> outputs cleared immediately without a clock edge, in_ready=1.

Source files
------------

// File: rtl/pipe_skid_reg_pkg.sv
// Shared pipeline-stage definitions: holding-state encoding and its occupancy mapping.
package pipe_skid_reg_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_MAIN  = 2'd1,
    ST_BOTH  = 2'd2
  } pipe_state_e;

  function automatic logic [1:0] state_occ(input pipe_state_e s);
    logic [1:0] occ;
    occ = 2'd0;
    case (s)
      ST_MAIN: occ = 2'd1;
      ST_BOTH: occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_skid_reg.sv
// Valid/ready pipeline register: two-entry skid buffer with registered in_ready,
// or a single-entry register with combinational in_ready (SKID_EN=0).
module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int SKID_EN      = 1,
  parameter int CLR_ON_FLUSH = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  // state | meaning
  // ST_EMPTY | nothing held, upstream may push
  // ST_MAIN  | one entry in main, presented downstream
  // ST_BOTH  | main presented, second entry parked in skid, upstream stalled

  if (SKID_EN != 0) begin : g_skid
    pipe_state_e       state, state_nxt;
    logic              ready_q;
    logic              xfer_in, xfer_out;
    logic [DATA_W-1:0] main_q, skid_q;

    assign xfer_in  = in_valid & ready_q;
    assign xfer_out = (state != ST_EMPTY) & out_ready;

    always_comb begin
      state_nxt = state;
      if (flush) begin
        state_nxt = ST_EMPTY;
      end else begin
        case (state)
          ST_EMPTY: if (xfer_in) state_nxt = ST_MAIN;
          ST_MAIN: begin
            if (xfer_in && !xfer_out)      state_nxt = ST_BOTH;
            else if (!xfer_in && xfer_out) state_nxt = ST_EMPTY;
          end
          ST_BOTH:  if (xfer_out) state_nxt = ST_MAIN;
          default:  state_nxt = ST_EMPTY;
        endcase
      end
    end

    // in_ready is registered from the next state so it never sees out_ready combinationally
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state   <= ST_EMPTY;
        ready_q <= 1'b1;
      end else begin
        state   <= state_nxt;
        ready_q <= (state_nxt != ST_BOTH);
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        main_q <= '0;
        skid_q <= '0;
      end else if (flush) begin
        if (CLR_ON_FLUSH != 0) begin
          main_q <= '0;
          skid_q <= '0;
        end
      end else begin
        case (state)
          ST_EMPTY: if (xfer_in) main_q <= in_data;
          ST_MAIN: begin
            if (xfer_in && xfer_out) main_q <= in_data;
            else if (xfer_in)        skid_q <= in_data;
          end
          ST_BOTH:  if (xfer_out) main_q <= skid_q;
          default: ;
        endcase
      end
    end

    assign in_ready  = ready_q;
    assign out_valid = (state != ST_EMPTY);
    assign out_data  = main_q;
    assign occupancy = state_occ(state);

  end else begin : g_reg
    logic              valid_q;
    logic              ready_c;
    logic [DATA_W-1:0] main_q;

    assign ready_c = ~valid_q | out_ready;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        valid_q <= 1'b0;
        main_q  <= '0;
      end else if (flush) begin
        valid_q <= 1'b0;
        if (CLR_ON_FLUSH != 0) main_q <= '0;
      end else if (in_valid && ready_c) begin
        valid_q <= 1'b1;
        main_q  <= in_data;
      end else if (valid_q && out_ready) begin
        valid_q <= 1'b0;
      end
    end

    assign in_ready  = ready_c;
    assign out_valid = valid_q;
    assign out_data  = main_q;
    assign occupancy = {1'b0, valid_q};
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: three shared-stimulus instances (skid, skid without clear,
// plain register) compared against a FIFO-level reference model.
module tb_pipe_skid_reg;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;

  logic [2:0]  ir;
  logic [2:0]  ov;
  logic [31:0] od [3];
  logic [1:0]  oc [3];

  int n_err;
  int n_checks;

  // reference model: per instance a small ordered store plus the last presented payload
  int          cnt  [3];
  logic [31:0] ent  [3][2];
  logic [31:0] hold [3];
  logic        mrdy [3];

  pipe_skid_reg #(.DATA_W(32), .SKID_EN(1), .CLR_ON_FLUSH(1)) u_skid (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .occupancy(oc[0])
  );

  pipe_skid_reg #(.DATA_W(32), .SKID_EN(1), .CLR_ON_FLUSH(0)) u_keep (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .occupancy(oc[1])
  );

  pipe_skid_reg #(.DATA_W(32), .SKID_EN(0), .CLR_ON_FLUSH(1)) u_reg (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(ir[2]), .in_data(in_data),
    .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]), .occupancy(oc[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_ready(input int k);
    if (k == 2) return (cnt[k] == 0) || out_ready;
    return cnt[k] < 2;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      cnt[k]  = 0;
      hold[k] = '0;
    end
  endtask

  task automatic check_out(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s_valid%0d", tag, k), {31'd0, ov[k]}, {31'd0, cnt[k] > 0});
      chk($sformatf("%s_data%0d", tag, k), od[k], hold[k]);
      chk($sformatf("%s_occ%0d", tag, k), {30'd0, oc[k]}, cnt[k]);
    end
  endtask

  // called at a falling edge; applies inputs, checks in_ready, clocks, checks outputs
  task automatic step(input logic iv, input logic [31:0] id, input logic ordy,
                      input logic fl, input string tag);
    logic tin, tout;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    #1;
    for (int k = 0; k < 3; k++) begin
      mrdy[k] = model_ready(k);
      chk($sformatf("%s_ready%0d", tag, k), {31'd0, ir[k]}, {31'd0, mrdy[k]});
    end
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < 3; k++) begin
        tin  = iv && mrdy[k];
        tout = (cnt[k] > 0) && ordy;
        if (fl) begin
          cnt[k] = 0;
          if (k != 1) hold[k] = '0;
        end else begin
          if (tout) begin
            ent[k][0] = ent[k][1];
            cnt[k]--;
          end
          if (tin) begin
            ent[k][cnt[k]] = id;
            cnt[k]++;
          end
          if (cnt[k] > 0) hold[k] = ent[k][0];
        end
      end
    end
    @(negedge clk);
    check_out(tag);
  endtask

  initial begin
    n_err = 0;
    n_checks = 0;
    rst = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_out("reset");
    for (int k = 0; k < 3; k++) chk($sformatf("reset_ready%0d", k), {31'd0, ir[k]}, 32'd1);
    rst = 1'b1;

    // streaming
    step(1'b1, 32'h11, 1'b1, 1'b0, "stream0");
    chk("stream_first", od[0], 32'h11);
    step(1'b1, 32'h22, 1'b1, 1'b0, "stream1");
    chk("stream_second", od[0], 32'h22);
    step(1'b1, 32'h33, 1'b1, 1'b0, "stream2");
    chk("stream_occ", {30'd0, oc[0]}, 32'd1);
    step(1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, "stream3");

    // backpressure then release
    step(1'b1, 32'hA, 1'b0, 1'b0, "bp0");
    step(1'b1, 32'hB, 1'b0, 1'b0, "bp1");
    chk("bp_stall", {31'd0, ir[0]}, 32'd0);
    step(1'b1, 32'hC, 1'b0, 1'b0, "bp2");
    chk("bp_hold_a", od[0], 32'hA);
    step(1'b1, 32'hC, 1'b1, 1'b0, "bp3");
    chk("bp_then_b", od[0], 32'hB);
    step(1'b1, 32'hC, 1'b1, 1'b0, "bp4");
    chk("bp_then_c", od[0], 32'hC);
    step(1'b0, 32'h0, 1'b1, 1'b0, "bp5");

    // flush colliding with an incoming payload while full
    step(1'b1, 32'h5A, 1'b0, 1'b0, "fl0");
    step(1'b1, 32'h6B, 1'b0, 1'b0, "fl1");
    step(1'b1, 32'hDEAD, 1'b0, 1'b1, "fl2");
    chk("flush_occ", {30'd0, oc[0]}, 32'd0);
    chk("flush_data", od[0], 32'd0);
    chk("flush_keep", od[1], 32'h5A);
    step(1'b0, 32'hDEAD, 1'b1, 1'b0, "fl3");

    // single-entry replacement while downstream drains
    step(1'b1, 32'h100, 1'b0, 1'b0, "rep0");
    step(1'b1, 32'h200, 1'b1, 1'b0, "rep1");
    chk("replace_data", od[2], 32'h200);
    step(1'b0, 32'h0, 1'b1, 1'b0, "rep2");

    // asynchronous reset between edges while full
    step(1'b1, 32'h31, 1'b0, 1'b0, "ar0");
    step(1'b1, 32'h32, 1'b0, 1'b0, "ar1");
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_out("async_rst");
    for (int k = 0; k < 3; k++) chk($sformatf("async_ready%0d", k), {31'd0, ir[k]}, 32'd1);
    in_valid = 1'b1;
    in_data = 32'h99;
    @(posedge clk);
    @(negedge clk);
    check_out("rst_held");
    rst = 1'b1;
    step(1'b1, 32'h77, 1'b1, 1'b0, "post_rst");
    chk("post_rst_data", od[0], 32'h77);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 10) < 7, $urandom, ($urandom % 10) < 6,
           ($urandom % 16) == 0, "rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
